// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: command sequencer for a single MAC block.
// Takes one command, pulses the MAC local reset to load the init value, and
// streams operand beats into the MAC. Results come back one per beat in
// multiply-only mode, or one per command in accumulate mode.
module mac_seq_ctrl #(
    parameter int MIN_W  = 8,
    parameter int ACC_W  = 32,
    parameter int CONF_W = 3,
    parameter int LEN_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [LEN_W-1:0]        cmd_len_i,
    input  logic [1:0]              cmd_mode_i,
    input  logic                    cmd_acc_i,
    input  logic [ACC_W-1:0]        cmd_init_i,
    input  logic                    op_valid_i,
    output logic                    op_ready_o,
    input  logic [MIN_W-1:0]        op_b0_i,
    input  logic [4*MIN_W-1:0]      op_a_i,
    output logic                    mac_rst_o,
    output logic                    mac_en_o,
    output logic [ACC_W+CONF_W-1:0] mac_cfg_o,
    output logic [MIN_W-1:0]        mac_b0_o,
    output logic [4*MIN_W-1:0]      mac_a_o,
    input  logic [ACC_W-1:0]        mac_c_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [ACC_W-1:0]        res_data_o,
    output logic                    busy_o,
    output logic                    err_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [ACC_W+CONF_W-1:0] cfg_q, cfg_d;
    logic [4*MIN_W-1:0]      a_q, a_d;
    logic [MIN_W-1:0]        b0_q, b0_d;
    logic                    en_q, en_d;
    logic                    capt_q, capt_d;
    logic                    res_valid_q, res_valid_d;
    logic [ACC_W-1:0]        res_data_q, res_data_d;
    logic                    err_q, err_d;

    logic                    acc_mode;
    logic [ACC_W-1:0]        cfg_init;
    logic                    op_ready;
    logic                    op_fire;

    // The accumulate flag sits just above the two mode bits, init above that.
    assign acc_mode = cfg_q[2];
    assign cfg_init = cfg_q[ACC_W+CONF_W-1:CONF_W];

    // Multiply-only mode allows one beat in flight and no unconsumed result,
    // so each result is drained before the next beat enters the MAC.
    always_comb begin
        op_ready = 1'b0;
        if (state_q == RUN) begin
            op_ready = acc_mode ? 1'b1 : (!en_q && !capt_q && !res_valid_q);
        end
    end

    assign op_fire = op_valid_i && op_ready;

    // Next-state and datapath update for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_d       = cfg_q;
        a_d         = a_q;
        b0_d        = b0_q;
        en_d        = 1'b0;
        capt_d      = en_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    cfg_d   = {cmd_init_i, cmd_acc_i,
                               (cmd_mode_i == 2'b11) ? 2'b00 : cmd_mode_i};
                    err_d   = (cmd_mode_i == 2'b11);
                    cnt_d   = cmd_len_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q == '0) begin
                    res_data_d  = acc_mode ? cfg_init : '0;
                    res_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (res_valid_q && res_ready_i) begin
                    res_valid_d = 1'b0;
                end
                if (capt_q && !acc_mode) begin
                    res_data_d  = mac_c_i;
                    res_valid_d = 1'b1;
                end
                if (op_fire) begin
                    a_d   = op_a_i;
                    b0_d  = op_b0_i;
                    en_d  = 1'b1;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (capt_q && !en_q) begin
                    res_data_d  = mac_c_i;
                    res_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; active-low synchronous reset aborts any command in progress.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cfg_q       <= '0;
            a_q         <= '0;
            b0_q        <= '0;
            en_q        <= 1'b0;
            capt_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_q       <= cfg_d;
            a_q         <= a_d;
            b0_q        <= b0_d;
            en_q        <= en_d;
            capt_q      <= capt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign op_ready_o  = op_ready;
    assign mac_rst_o   = (state_q == LOAD);
    assign mac_en_o    = en_q;
    assign mac_cfg_o   = cfg_q;
    assign mac_b0_o    = b0_q;
    assign mac_a_o     = a_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed bench for the MAC command sequencer, with a
// behavioural MAC attached to the sequencer's MAC-side ports.
module tb_mac_seq_ctrl;

    localparam int MIN_W  = 8;
    localparam int ACC_W  = 32;
    localparam int CONF_W = 3;
    localparam int LEN_W  = 8;

    logic                    clk;
    logic                    rst;
    logic                    cmdValid;
    logic                    cmdReady;
    logic [LEN_W-1:0]        cmdLen;
    logic [1:0]              cmdMode;
    logic                    cmdAcc;
    logic [ACC_W-1:0]        cmdInit;
    logic                    opValid;
    logic                    opReady;
    logic [MIN_W-1:0]        opB0;
    logic [4*MIN_W-1:0]      opA;
    logic                    macRst;
    logic                    macEn;
    logic [ACC_W+CONF_W-1:0] macCfg;
    logic [MIN_W-1:0]        macB0;
    logic [4*MIN_W-1:0]      macA;
    logic [ACC_W-1:0]        macC;
    logic                    resValid;
    logic                    resReady;
    logic [ACC_W-1:0]        resData;
    logic                    busy;
    logic                    err;

    int checks   = 0;
    int failures = 0;
    int macEnCount = 0;

    mac_seq_ctrl #(
        .MIN_W(MIN_W), .ACC_W(ACC_W), .CONF_W(CONF_W), .LEN_W(LEN_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_len_i(cmdLen),
        .cmd_mode_i(cmdMode), .cmd_acc_i(cmdAcc), .cmd_init_i(cmdInit),
        .op_valid_i(opValid), .op_ready_o(opReady), .op_b0_i(opB0), .op_a_i(opA),
        .mac_rst_o(macRst), .mac_en_o(macEn), .mac_cfg_o(macCfg),
        .mac_b0_o(macB0), .mac_a_o(macA), .mac_c_i(macC),
        .res_valid_o(resValid), .res_ready_i(resReady), .res_data_o(resData),
        .busy_o(busy), .err_o(err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural MAC: mode picks how many A slices form the multiplicand.
    logic [ACC_W-1:0] macAcc = '0;
    logic [ACC_W-1:0] macProd;
    always_comb begin
        case (macCfg[1:0])
            2'b00:   macProd = ACC_W'(macA[7:0])  * ACC_W'(macB0);
            2'b01:   macProd = ACC_W'(macA[15:0]) * ACC_W'(macB0);
            default: macProd = ACC_W'(macA)       * ACC_W'(macB0);
        endcase
    end

    // Accumulator register of the MAC; local reset loads init.
    always @(posedge clk) begin
        if (macRst) begin
            macAcc <= macCfg[ACC_W+CONF_W-1:CONF_W];
        end else if (macEn) begin
            macAcc <= (macCfg[2] ? macAcc : '0) + macProd;
        end
    end
    assign macC = macAcc;

    // Counts enable pulses so commands can be checked for stray MAC activity.
    always @(posedge clk) begin
        if (macEn === 1'b1) macEnCount <= macEnCount + 1;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic [LEN_W-1:0] len, input logic [1:0] mode,
                           input logic acc, input logic [ACC_W-1:0] init);
        int n = 0;
        cmdLen = len; cmdMode = mode; cmdAcc = acc; cmdInit = init;
        cmdValid = 1'b1;
        while (cmdReady !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (cmdReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cmd_accept: cmd_ready=%b required 1 within 50 cycles", cmdReady);
        end
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic sendBeat(input logic [4*MIN_W-1:0] a, input logic [MIN_W-1:0] b);
        int n = 0;
        opA = a; opB0 = b;
        opValid = 1'b1;
        while (opReady !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (opReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL op_accept: op_ready=%b required 1 within 50 cycles", opReady);
        end
        tick();
        opValid = 1'b0;
    endtask

    task automatic waitResult(input int maxCycles);
        int n = 0;
        while (resValid !== 1'b1 && n < maxCycles) begin
            tick();
            n++;
        end
        checks++;
        if (resValid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL res_wait: res_valid=%b required 1 within %0d cycles", resValid, maxCycles);
        end
    endtask

    task automatic handshake();
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cmdValid = 1'b0; cmdLen = '0; cmdMode = '0; cmdAcc = 1'b0; cmdInit = '0;
        opValid = 1'b0; opA = '0; opB0 = '0; resReady = 1'b0;
        tick();
        tick();
        checks++;
        if (cmdReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_cmd_ready: got %b required 1", cmdReady);
        end
        checks++;
        if ({opReady, macRst, macEn, resValid, busy, err} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: op_ready/mac_rst/mac_en/res_valid/busy/err=%b required 000000",
                     {opReady, macRst, macEn, resValid, busy, err});
        end
        checks++;
        if ({macCfg, macB0, macA, resData} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: cfg=%h b0=%h a=%h res=%h required all 0",
                     macCfg, macB0, macA, resData);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_run();
        sendCmd(8'd5, 2'b00, 1'b1, 32'd0);
        sendBeat(32'd2, 8'd3);
        sendBeat(32'd4, 8'd5);
        checks++;
        if (busy !== 1'b1 || macEn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midrun_active: busy=%b mac_en=%b required 1 1", busy, macEn);
        end
        opValid = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        opValid = 1'b0;
        checks++;
        if ({busy, resValid, cmdReady, macEn, opReady} !== 5'b00100) begin
            failures++;
            $display("[TB] FAIL midrun_abort: busy/res_valid/cmd_ready/mac_en/op_ready=%b required 00100",
                     {busy, resValid, cmdReady, macEn, opReady});
        end
        tick();
        checks++;
        if (busy !== 1'b0 || resValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrun_idle: busy=%b res_valid=%b required 0 0", busy, resValid);
        end
    endtask

    task automatic test_acc_single();
        sendCmd(8'd3, 2'b00, 1'b1, 32'd10);
        sendBeat(32'd2, 8'd3);
        sendBeat(32'd4, 8'd5);
        sendBeat(32'd1, 8'd7);
        checks++;
        if (resValid !== 1'b0 || macEn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL acc_t1: res_valid=%b mac_en=%b required 0 1", resValid, macEn);
        end
        tick();
        checks++;
        if (resValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL acc_t2: res_valid=%b required 0", resValid);
        end
        tick();
        checks++;
        if (resValid !== 1'b1 || resData !== 32'd43) begin
            failures++;
            $display("[TB] FAIL acc_result: valid=%b data=%0d required 1 43", resValid, resData);
        end
        handshake();
        checks++;
        if (resValid !== 1'b0 || cmdReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL acc_done: res_valid=%b cmd_ready=%b required 0 1", resValid, cmdReady);
        end
    endtask

    task automatic test_mult_dual();
        sendCmd(8'd2, 2'b01, 1'b0, 32'd0);
        sendBeat({16'h0000, 8'd1, 8'd2}, 8'd3);
        checks++;
        if (opReady !== 1'b0 || resValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dual_inflight: op_ready=%b res_valid=%b required 0 0", opReady, resValid);
        end
        tick();
        tick();
        checks++;
        if (resValid !== 1'b1 || resData !== 32'd774) begin
            failures++;
            $display("[TB] FAIL dual_res1: valid=%b data=%0d required 1 774", resValid, resData);
        end
        tick();
        checks++;
        if (resValid !== 1'b1 || resData !== 32'd774 || opReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dual_hold: valid=%b data=%0d op_ready=%b required 1 774 0",
                     resValid, resData, opReady);
        end
        handshake();
        checks++;
        if (resValid !== 1'b0 || opReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dual_next: res_valid=%b op_ready=%b required 0 1", resValid, opReady);
        end
        sendBeat({16'h0000, 8'd0, 8'd255}, 8'd255);
        waitResult(10);
        checks++;
        if (resData !== 32'd65025 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dual_res2: data=%0d busy=%b required 65025 1", resData, busy);
        end
        handshake();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dual_done: busy=%b required 0", busy);
        end
    endtask

    task automatic test_len_zero();
        int startEn;
        startEn = macEnCount;
        sendCmd(8'd0, 2'b00, 1'b1, 32'h0000DEAD);
        checks++;
        if (macRst !== 1'b1) begin
            failures++;
            $display("[TB] FAIL len0_macrst: mac_rst=%b required 1", macRst);
        end
        tick();
        checks++;
        if (resValid !== 1'b1 || resData !== 32'h0000DEAD) begin
            failures++;
            $display("[TB] FAIL len0_result: valid=%b data=%h required 1 0000dead", resValid, resData);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (resValid !== 1'b1 || resData !== 32'h0000DEAD) begin
                failures++;
                $display("[TB] FAIL len0_stable: cycle %0d valid=%b data=%h required 1 0000dead",
                         i, resValid, resData);
            end
        end
        checks++;
        if (macEnCount - startEn !== 0) begin
            failures++;
            $display("[TB] FAIL len0_no_en: mac_en pulses=%0d required 0", macEnCount - startEn);
        end
        handshake();
        checks++;
        if (busy !== 1'b0 || resValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL len0_done: busy=%b res_valid=%b required 0 0", busy, resValid);
        end
    endtask

    task automatic test_illegal_mode();
        sendCmd(8'd1, 2'b11, 1'b0, 32'd0);
        checks++;
        if (err !== 1'b1 || macCfg[1:0] !== 2'b00) begin
            failures++;
            $display("[TB] FAIL illegal_err: err=%b mode=%b required 1 00", err, macCfg[1:0]);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL illegal_pulse: err=%b required 0", err);
        end
        sendBeat(32'd3, 8'd4);
        waitResult(10);
        checks++;
        if (resData !== 32'd12) begin
            failures++;
            $display("[TB] FAIL illegal_result: data=%0d required 12", resData);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        cmdLen = 8'd1; cmdMode = 2'b00; cmdAcc = 1'b1; cmdInit = 32'hFFFFFFFF;
        cmdValid = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || cmdReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_accept: busy=%b cmd_ready=%b required 1 0", busy, cmdReady);
        end
        sendBeat(32'd1, 8'd1);
        waitResult(10);
        checks++;
        if (resData !== 32'd0 || cmdReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_wrap: data=%h cmd_ready=%b required 00000000 0", resData, cmdReady);
        end
        cmdLen = 8'd0; cmdInit = 32'h00001234;
        handshake();
        checks++;
        if (cmdReady !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_idle: cmd_ready=%b busy=%b required 1 0", cmdReady, busy);
        end
        tick();
        cmdValid = 1'b0;
        checks++;
        if (busy !== 1'b1 || macCfg[ACC_W+CONF_W-1:CONF_W] !== 32'h00001234) begin
            failures++;
            $display("[TB] FAIL b2b_second: busy=%b init=%h required 1 00001234",
                     busy, macCfg[ACC_W+CONF_W-1:CONF_W]);
        end
        tick();
        checks++;
        if (resValid !== 1'b1 || resData !== 32'h00001234) begin
            failures++;
            $display("[TB] FAIL b2b_result: valid=%b data=%h required 1 00001234", resValid, resData);
        end
        handshake();
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        test_reset();
        test_reset_mid_run();
        test_acc_single();
        test_mult_dual();
        test_len_zero();
        test_illegal_mode();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
